// File: rtl/mem_pkg.sv
// Shared types and widths for the memory stage: FSM state, EX/MEM and MEM/WB
// register layouts, and the word-alignment helper.
package mem_pkg;
  localparam int DATA_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int RESULT_SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                    valid;
    logic [DATA_W-1:0]       alu_out;
    logic [DATA_W-1:0]       pc_next;
    logic [DATA_W-1:0]       lr_wrt_data;
    logic [1:0]              fl_wrt_data;
    logic                    mem_en;
    logic                    mem_wrt;
    logic                    reg_wrt_en;
    logic [RESULT_SEL_W-1:0] result_sel;
    logic [REG_ADDR_W-1:0]   wrt_reg;
  } exme_t;

  typedef struct packed {
    logic                    valid;
    logic [DATA_W-1:0]       alu_out;
    logic [DATA_W-1:0]       mem_data;
    logic [DATA_W-1:0]       pc_next;
    logic [DATA_W-1:0]       lr_wrt_data;
    logic [1:0]              fl_wrt_data;
    logic                    reg_wrt_en;
    logic [RESULT_SEL_W-1:0] result_sel;
    logic [REG_ADDR_W-1:0]   wrt_reg;
  } mewb_t;

  function automatic logic is_aligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and data memory (slave).
interface mem_stage_if import mem_pkg::*; ();
  // dmem_req rises with we/addr/wdata already valid and all four stay stable
  // until the single-cycle dmem_ack; dmem_rdata is only meaningful with ack.
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/dmem_ctrl.sv
// Request/ack access FSM with timeout; owns the registered dmem request fields.
module dmem_ctrl import mem_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              req_o,
  output logic              we_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output mem_state_e        state_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          cnt_d   = '0;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      ACCESS: begin
        if (ack || cnt_q == CNT_LAST) state_d = IDLE;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is the registered state itself, so reset drops it at once.
  assign busy    = (state_q == ACCESS);
  assign done    = busy && ack;
  assign timeout = busy && !ack && (cnt_q == CNT_LAST);
  assign req_o   = busy;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign state_o = state_q;
endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM and MEM/WB registers, alignment check, sticky
// error flag, and the data-memory access controller.
module mem_stage import mem_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    ExMe_in_valid,
  input  logic [DATA_W-1:0]       ExMe_in_alu_out,
  input  logic [DATA_W-1:0]       ExMe_in_reg_2,
  input  logic [DATA_W-1:0]       ExMe_in_PC_next,
  input  logic [DATA_W-1:0]       ExMe_in_LR_wrt_data,
  input  logic [1:0]              ExMe_in_FL_wrt_data,
  input  logic                    ExMe_in_mem_en,
  input  logic                    ExMe_in_mem_wrt,
  input  logic                    ExMe_in_reg_wrt_en,
  input  logic [RESULT_SEL_W-1:0] ExMe_in_result_sel,
  input  logic [REG_ADDR_W-1:0]   ExMe_in_wrt_reg,
  output logic [DATA_W-1:0]       ExMe_out_alu_out,
  output logic                    mem_stall,
  mem_stage_if.master             dmem,
  output logic                    MeWb_out_valid,
  output logic [DATA_W-1:0]       MeWb_out_alu_out,
  output logic [DATA_W-1:0]       MeWb_out_mem_data,
  output logic [DATA_W-1:0]       MeWb_out_PC_next,
  output logic [DATA_W-1:0]       MeWb_out_LR_wrt_data,
  output logic [1:0]              MeWb_out_FL_wrt_data,
  output logic                    MeWb_out_reg_wrt_en,
  output logic [RESULT_SEL_W-1:0] MeWb_out_result_sel,
  output logic [REG_ADDR_W-1:0]   MeWb_out_wrt_reg,
  output logic                    mem_err,
  output mem_state_e              dbg_state
);
  exme_t exme_q, exme_d;
  mewb_t mewb_q, mewb_d;
  logic  mem_err_q, mem_err_d;
  logic  busy, done, timeout, start, misaligned;

  // Accesses launch on the same edge that loads EX/MEM, so the request is
  // built from the incoming EX values rather than the registered copy.
  assign start = !busy && !flush && ExMe_in_valid && ExMe_in_mem_en
                 && is_aligned(ExMe_in_alu_out);
  assign misaligned = !busy && exme_q.valid && exme_q.mem_en
                      && !is_aligned(exme_q.alu_out);

  dmem_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .we      (ExMe_in_mem_wrt),
    .addr    (ExMe_in_alu_out),
    .wdata   (ExMe_in_reg_2),
    .ack     (dmem.dmem_ack),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .req_o   (dmem.dmem_req),
    .we_o    (dmem.dmem_we),
    .addr_o  (dmem.dmem_addr),
    .wdata_o (dmem.dmem_wdata),
    .state_o (dbg_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exme_q    <= '0;
      mewb_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      exme_q    <= exme_d;
      mewb_q    <= mewb_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    exme_d = exme_q;
    if (!busy) begin
      exme_d.valid       = ExMe_in_valid && !flush;
      exme_d.alu_out     = ExMe_in_alu_out;
      exme_d.pc_next     = ExMe_in_PC_next;
      exme_d.lr_wrt_data = ExMe_in_LR_wrt_data;
      exme_d.fl_wrt_data = ExMe_in_FL_wrt_data;
      exme_d.mem_en      = ExMe_in_mem_en;
      exme_d.mem_wrt     = ExMe_in_mem_wrt;
      exme_d.reg_wrt_en  = ExMe_in_reg_wrt_en && !flush;
      exme_d.result_sel  = ExMe_in_result_sel;
      exme_d.wrt_reg     = ExMe_in_wrt_reg;
    end
  end

  // Default is a bubble. A memory op sitting in EX/MEM while IDLE has either
  // already completed or was misaligned, so it never reaches MEM/WB twice.
  always_comb begin
    mewb_d = '0;
    if ((busy && done) || (!busy && exme_q.valid && !exme_q.mem_en)) begin
      mewb_d.valid       = exme_q.valid;
      mewb_d.alu_out     = exme_q.alu_out;
      mewb_d.mem_data    = (busy && !exme_q.mem_wrt) ? dmem.dmem_rdata : '0;
      mewb_d.pc_next     = exme_q.pc_next;
      mewb_d.lr_wrt_data = exme_q.lr_wrt_data;
      mewb_d.fl_wrt_data = exme_q.fl_wrt_data;
      mewb_d.reg_wrt_en  = exme_q.reg_wrt_en;
      mewb_d.result_sel  = exme_q.result_sel;
      mewb_d.wrt_reg     = exme_q.wrt_reg;
    end
    mem_err_d = mem_err_q || timeout || misaligned;
  end

  assign mem_stall            = busy;
  assign ExMe_out_alu_out     = exme_q.alu_out;
  assign mem_err              = mem_err_q;
  assign MeWb_out_valid       = mewb_q.valid;
  assign MeWb_out_alu_out     = mewb_q.alu_out;
  assign MeWb_out_mem_data    = mewb_q.mem_data;
  assign MeWb_out_PC_next     = mewb_q.pc_next;
  assign MeWb_out_LR_wrt_data = mewb_q.lr_wrt_data;
  assign MeWb_out_FL_wrt_data = mewb_q.fl_wrt_data;
  assign MeWb_out_reg_wrt_en  = mewb_q.reg_wrt_en;
  assign MeWb_out_result_sel  = mewb_q.result_sel;
  assign MeWb_out_wrt_reg     = mewb_q.wrt_reg;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, flush, load, store with
// wait states, timeout, misalignment and asynchronous reset mid-access.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        ExMe_in_valid, ExMe_in_mem_en, ExMe_in_mem_wrt, ExMe_in_reg_wrt_en;
  logic [31:0] ExMe_in_alu_out, ExMe_in_reg_2, ExMe_in_PC_next, ExMe_in_LR_wrt_data;
  logic [1:0]  ExMe_in_FL_wrt_data, ExMe_in_result_sel;
  logic [4:0]  ExMe_in_wrt_reg;
  logic [31:0] ExMe_out_alu_out;
  logic        mem_stall, mem_err;
  logic        MeWb_out_valid, MeWb_out_reg_wrt_en;
  logic [31:0] MeWb_out_alu_out, MeWb_out_mem_data, MeWb_out_PC_next, MeWb_out_LR_wrt_data;
  logic [1:0]  MeWb_out_FL_wrt_data, MeWb_out_result_sel;
  logic [4:0]  MeWb_out_wrt_reg;
  mem_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ExMe_in_valid(ExMe_in_valid), .ExMe_in_alu_out(ExMe_in_alu_out),
    .ExMe_in_reg_2(ExMe_in_reg_2), .ExMe_in_PC_next(ExMe_in_PC_next),
    .ExMe_in_LR_wrt_data(ExMe_in_LR_wrt_data), .ExMe_in_FL_wrt_data(ExMe_in_FL_wrt_data),
    .ExMe_in_mem_en(ExMe_in_mem_en), .ExMe_in_mem_wrt(ExMe_in_mem_wrt),
    .ExMe_in_reg_wrt_en(ExMe_in_reg_wrt_en), .ExMe_in_result_sel(ExMe_in_result_sel),
    .ExMe_in_wrt_reg(ExMe_in_wrt_reg), .ExMe_out_alu_out(ExMe_out_alu_out),
    .mem_stall(mem_stall), .dmem(dmem_bus.master),
    .MeWb_out_valid(MeWb_out_valid), .MeWb_out_alu_out(MeWb_out_alu_out),
    .MeWb_out_mem_data(MeWb_out_mem_data), .MeWb_out_PC_next(MeWb_out_PC_next),
    .MeWb_out_LR_wrt_data(MeWb_out_LR_wrt_data), .MeWb_out_FL_wrt_data(MeWb_out_FL_wrt_data),
    .MeWb_out_reg_wrt_en(MeWb_out_reg_wrt_en), .MeWb_out_result_sel(MeWb_out_result_sel),
    .MeWb_out_wrt_reg(MeWb_out_wrt_reg), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    flush = 1'b0; ExMe_in_valid = 1'b0; ExMe_in_alu_out = '0; ExMe_in_reg_2 = '0;
    ExMe_in_PC_next = '0; ExMe_in_LR_wrt_data = '0; ExMe_in_FL_wrt_data = '0;
    ExMe_in_mem_en = 1'b0; ExMe_in_mem_wrt = 1'b0; ExMe_in_reg_wrt_en = 1'b0;
    ExMe_in_result_sel = '0; ExMe_in_wrt_reg = '0;
  endtask

  task automatic drive_ex(input logic [31:0] alu, input logic mem_en, input logic mem_wrt,
                          input logic [31:0] reg2, input logic [4:0] rd);
    clear_ex();
    ExMe_in_valid = 1'b1; ExMe_in_alu_out = alu; ExMe_in_mem_en = mem_en;
    ExMe_in_mem_wrt = mem_wrt; ExMe_in_reg_2 = reg2; ExMe_in_wrt_reg = rd;
    ExMe_in_reg_wrt_en = !mem_wrt; ExMe_in_PC_next = 32'h40; ExMe_in_LR_wrt_data = 32'h44;
    ExMe_in_FL_wrt_data = 2'b10; ExMe_in_result_sel = 2'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_ex();
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    #12;
    n_cmp++; if ({dmem_bus.dmem_req, mem_stall, mem_err, MeWb_out_valid} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {dmem_bus.dmem_req, mem_stall, mem_err, MeWb_out_valid}); end
    n_cmp++; if ({MeWb_out_alu_out, MeWb_out_mem_data, ExMe_out_alu_out} !== 96'h0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", {MeWb_out_alu_out, MeWb_out_mem_data, ExMe_out_alu_out}); end
    n_cmp++; if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive_ex(32'h1234, 1'b0, 1'b0, 32'h0, 5'd3);
    tick();
    n_cmp++; if (ExMe_out_alu_out !== 32'h1234) begin
      n_err++; $display("FAIL alu_fwd: got %h expected 00001234", ExMe_out_alu_out); end
    n_cmp++; if ({mem_stall, dmem_bus.dmem_req} !== 2'b00) begin
      n_err++; $display("FAIL alu_nostall: got %b expected 00", {mem_stall, dmem_bus.dmem_req}); end
    clear_ex();
    tick();
    n_cmp++; if ({MeWb_out_valid, MeWb_out_alu_out, MeWb_out_mem_data, MeWb_out_wrt_reg, MeWb_out_reg_wrt_en}
                 !== {1'b1, 32'h1234, 32'h0, 5'd3, 1'b1}) begin
      n_err++; $display("FAIL alu_mewb: got v=%b a=%h d=%h rd=%0d we=%b expected v=1 a=00001234 d=0 rd=3 we=1",
                        MeWb_out_valid, MeWb_out_alu_out, MeWb_out_mem_data, MeWb_out_wrt_reg, MeWb_out_reg_wrt_en); end
    n_cmp++; if ({MeWb_out_PC_next, MeWb_out_LR_wrt_data, MeWb_out_FL_wrt_data, MeWb_out_result_sel}
                 !== {32'h40, 32'h44, 2'b10, 2'd1}) begin
      n_err++; $display("FAIL alu_side: got pc=%h lr=%h fl=%b sel=%0d expected 40/44/10/1",
                        MeWb_out_PC_next, MeWb_out_LR_wrt_data, MeWb_out_FL_wrt_data, MeWb_out_result_sel); end
  endtask

  task automatic test_flush();
    drive_ex(32'h99, 1'b0, 1'b0, 32'h0, 5'd4);
    flush = 1'b1;
    tick();
    clear_ex();
    tick();
    n_cmp++; if ({MeWb_out_valid, MeWb_out_reg_wrt_en} !== 2'b00) begin
      n_err++; $display("FAIL flush_bubble: got %b expected 00", {MeWb_out_valid, MeWb_out_reg_wrt_en}); end
  endtask

  task automatic test_load();
    drive_ex(32'h100, 1'b1, 1'b0, 32'h0, 5'd5);
    tick();
    n_cmp++; if ({mem_stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr} !== {3'b110, 32'h100}) begin
      n_err++; $display("FAIL load_req: got stall=%b req=%b we=%b addr=%h expected 1/1/0/00000100",
                        mem_stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr); end
    clear_ex();
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    n_cmp++; if ({mem_stall, dmem_bus.dmem_req} !== 2'b00) begin
      n_err++; $display("FAIL load_release: got %b expected 00", {mem_stall, dmem_bus.dmem_req}); end
    n_cmp++; if ({MeWb_out_valid, MeWb_out_mem_data, MeWb_out_wrt_reg, MeWb_out_alu_out} !== {1'b1, 32'hDEADBEEF, 5'd5, 32'h100}) begin
      n_err++; $display("FAIL load_mewb: got v=%b d=%h rd=%0d a=%h expected 1/deadbeef/5/00000100",
                        MeWb_out_valid, MeWb_out_mem_data, MeWb_out_wrt_reg, MeWb_out_alu_out); end
    tick();
    n_cmp++; if ({MeWb_out_valid, dmem_bus.dmem_req} !== 2'b00) begin
      n_err++; $display("FAIL load_no_dup: got %b expected 00", {MeWb_out_valid, dmem_bus.dmem_req}); end
  endtask

  task automatic test_store_wait();
    drive_ex(32'h200, 1'b1, 1'b1, 32'hCAFEF00D, 5'd0);
    tick();
    drive_ex(32'h55, 1'b0, 1'b0, 32'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({mem_stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wdata, dmem_bus.dmem_addr, ExMe_out_alu_out}
                   !== {3'b111, 32'hCAFEF00D, 32'h200, 32'h200}) begin
        n_err++; $display("FAIL store_hold[%0d]: got stall=%b req=%b we=%b wd=%h addr=%h fwd=%h expected 1/1/1/cafef00d/200/200",
                          i, mem_stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wdata, dmem_bus.dmem_addr, ExMe_out_alu_out); end
      if (i == 3) dmem_bus.dmem_ack = 1'b1;
      tick();
      dmem_bus.dmem_ack = 1'b0;
    end
    n_cmp++; if ({mem_stall, dmem_bus.dmem_req, MeWb_out_valid, MeWb_out_mem_data, ExMe_out_alu_out}
                 !== {3'b001, 32'h0, 32'h200}) begin
      n_err++; $display("FAIL store_done: got stall=%b req=%b v=%b d=%h fwd=%h expected 0/0/1/0/200",
                        mem_stall, dmem_bus.dmem_req, MeWb_out_valid, MeWb_out_mem_data, ExMe_out_alu_out); end
    tick();
    clear_ex();
    n_cmp++; if ({ExMe_out_alu_out, MeWb_out_valid} !== {32'h55, 1'b0}) begin
      n_err++; $display("FAIL store_next_load: got fwd=%h v=%b expected 55/0", ExMe_out_alu_out, MeWb_out_valid); end
    tick();
    n_cmp++; if ({MeWb_out_valid, MeWb_out_alu_out, MeWb_out_wrt_reg} !== {1'b1, 32'h55, 5'd7}) begin
      n_err++; $display("FAIL store_next_wb: got v=%b a=%h rd=%0d expected 1/55/7", MeWb_out_valid, MeWb_out_alu_out, MeWb_out_wrt_reg); end
  endtask

  task automatic test_timeout();
    int n_req = 0;
    n_cmp++; if (mem_err !== 1'b0) begin
      n_err++; $display("FAIL err_clear_before_to: got %b expected 0", mem_err); end
    drive_ex(32'h300, 1'b1, 1'b0, 32'h0, 5'd6);
    tick();
    clear_ex();
    while (dmem_bus.dmem_req === 1'b1 && n_req < 40) begin
      n_req++;
      tick();
    end
    n_cmp++; if (n_req !== 16) begin
      n_err++; $display("FAIL timeout_len: got %0d req cycles expected 16", n_req); end
    n_cmp++; if ({mem_err, MeWb_out_valid, mem_stall} !== 3'b100) begin
      n_err++; $display("FAIL timeout_flags: got err/v/stall=%b expected 100", {mem_err, MeWb_out_valid, mem_stall}); end
    drive_ex(32'h77, 1'b0, 1'b0, 32'h0, 5'd8);
    tick();
    clear_ex();
    tick();
    n_cmp++; if ({MeWb_out_valid, MeWb_out_alu_out, mem_err} !== {1'b1, 32'h77, 1'b1}) begin
      n_err++; $display("FAIL timeout_resume: got v=%b a=%h err=%b expected 1/77/1", MeWb_out_valid, MeWb_out_alu_out, mem_err); end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive_ex(32'h102, 1'b1, 1'b0, 32'h0, 5'd9);
    tick();
    clear_ex();
    n_cmp++; if ({dmem_bus.dmem_req, mem_stall, mem_err} !== 3'b000) begin
      n_err++; $display("FAIL misal_first: got req/stall/err=%b expected 000", {dmem_bus.dmem_req, mem_stall, mem_err}); end
    tick();
    n_cmp++; if ({mem_err, MeWb_out_valid, MeWb_out_reg_wrt_en, dmem_bus.dmem_req, mem_stall} !== 5'b10000) begin
      n_err++; $display("FAIL misal_err: got err/v/we/req/stall=%b expected 10000",
                        {mem_err, MeWb_out_valid, MeWb_out_reg_wrt_en, dmem_bus.dmem_req, mem_stall}); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    drive_ex(32'h400, 1'b1, 1'b0, 32'h0, 5'd10);
    tick();
    clear_ex();
    tick();
    n_cmp++; if ({dmem_bus.dmem_req, mem_stall} !== 2'b11) begin
      n_err++; $display("FAIL rst_pre: got req/stall=%b expected 11", {dmem_bus.dmem_req, mem_stall}); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({dmem_bus.dmem_req, mem_stall, MeWb_out_valid, MeWb_out_reg_wrt_en, ExMe_out_alu_out, MeWb_out_alu_out}
                 !== {4'b0, 32'h0, 32'h0}) begin
      n_err++; $display("FAIL rst_async: got req=%b stall=%b v=%b we=%b fwd=%h a=%h expected all 0",
                        dmem_bus.dmem_req, mem_stall, MeWb_out_valid, MeWb_out_reg_wrt_en, ExMe_out_alu_out, MeWb_out_alu_out); end
    rst_n = 1'b1;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h11111111;
    tick();
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    n_cmp++; if ({MeWb_out_valid, MeWb_out_mem_data, dmem_bus.dmem_req, dmem_state_bit()} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL late_ack: got v=%b d=%h req=%b state=%0d expected 0/0/0/IDLE",
                        MeWb_out_valid, MeWb_out_mem_data, dmem_bus.dmem_req, dbg_state); end
  endtask

  function automatic logic dmem_state_bit();
    return (dbg_state == ACCESS);
  endfunction

  initial begin
    test_reset();
    test_alu();
    test_flush();
    test_load();
    test_store_wait();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
